// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: small FWFT FIFO with write acknowledge and redirect flush.
// Optional sticky overflow/underflow flags enabled by defining PIPE_BUF_ERR_EN.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned PTR_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              buf_we,
  input  logic [DATA_W-1:0] buf_din,
  output logic              buf_ack,
  output logic              buf_full,
  input  logic              buf_re,
  output logic              buf_avail,
  output logic [DATA_W-1:0] buf_dout,
  output logic [PTR_W:0]    buf_cnt,
  output logic [1:0]        buf_err
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              ack;
  logic              rd_fire_c;
  logic              wr_fire_c;

  // A pop frees a slot in the same cycle, so a full buffer still accepts a write alongside it.
  assign rd_fire_c = buf_re && (count != '0);
  assign wr_fire_c = buf_we && ((count != FULL_CNT) || rd_fire_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ack    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ack    <= 1'b0;
    end else begin
      ack <= wr_fire_c;
      if (wr_fire_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_fire_c) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_fire_c, rd_fire_c})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_fire_c) mem[wr_ptr] <= buf_din;
  end

  assign buf_ack   = ack;
  assign buf_full  = (count == FULL_CNT);
  assign buf_avail = (count != '0);
  assign buf_cnt   = count;
  assign buf_dout  = mem[rd_ptr];

`ifdef PIPE_BUF_ERR_EN
  logic [1:0] err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 2'b00;
    end else if (!flush) begin
      if (buf_we && (count == FULL_CNT) && !rd_fire_c) begin
        err[0] <= 1'b1;
        $display("BUF:overflow cnt=%0d", buf_cnt);
      end
      if (buf_re && (count == '0)) begin
        err[1] <= 1'b1;
        $display("BUF:underflow cnt=%0d", buf_cnt);
      end
    end
  end

  assign buf_err = err;
`else
  assign buf_err = 2'b00;
`endif

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Inter-stage pipeline buffer: the responder on the stage handshake. An upstream stage writes decoded bundles with buf_we; the downstream stage sees buf_avail and pops with buf_re.
- Small synchronous FIFO with first-word-fall-through output, write acknowledge, and flush on branch/jump redirect.
- Sits between ID and EX; sized so one instance also serves the IF/ID and EX/MA boundaries.

Parameters:
- DATA_W, 160: payload width; the ID/EX bundle is pc, alu_op, alu_c, rd, rs1, rs2, opr1, opr2, val, jp/br/wb_e, rw_e, rw_len, packed by the instantiator.
- DEPTH, 2: entry count; power of two, at least 2.
- PTR_W, 1: log2(DEPTH).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- flush, input, 1: discard all entries. Synchronous, sampled at the rising edge.
- buf_we, input, 1: write request from the upstream stage, sampled each rising edge.
- buf_din, input, DATA_W: write payload, valid while buf_we is high.
- buf_ack, output, 1: registered one-cycle pulse confirming an accepted write.
- buf_full, output, 1: count equals DEPTH.
- buf_re, input, 1: read/pop request from the downstream stage.
- buf_avail, output, 1: count not equal to 0.
- buf_dout, output, DATA_W: head entry (first-word-fall-through); value is undefined when empty.
- buf_cnt, output, PTR_W+1: current occupancy, 0 to DEPTH.
- buf_err, output, 2: sticky error flags, bit0 overflow, bit1 underflow (see Optional Feature).

Behaviour:
- Reset (async, immediate):
  - wr_ptr, rd_ptr and count go to 0.
  - buf_ack, buf_err, buf_full, buf_avail and buf_cnt are 0.
  - buf_dout reads storage entry 0, whose content is don't-care.
  - Storage contents are not cleared.
  - Reset mid-transfer discards all entries; no ack is issued for a write in flight.
- rd_fire = buf_re and avail.
- wr_fire = buf_we and (not full, or rd_fire). A write into a full buffer with a same-cycle pop is accepted.
- Each edge, when flush is 0:
  - If wr_fire: store buf_din at wr_ptr, then increment wr_ptr (wraps modulo DEPTH).
  - If rd_fire: increment rd_ptr (wraps).
  - count increments by 1 for wr_fire only, decrements by 1 for rd_fire only, and is unchanged when both fire.
- buf_ack is registered and equals wr_fire of the previous cycle: high exactly one cycle after each accepted write. A dropped write produces no ack.
- Latency: a write at edge N makes buf_avail high and buf_dout valid after edge N (visible in cycle N+1). There is no same-cycle bypass from buf_din to buf_dout.
- Empty buffer with buf_re: ignored, pointers unchanged.
- Full buffer with buf_we and no buf_re: write dropped, no ack, contents unchanged.
- Flush has priority over buf_we and buf_re in the same cycle:
  - Pointers and count go to 0 at that edge.
  - The concurrent write is dropped and buf_ack is 0 in the next cycle.
  - buf_err is not cleared by flush.
- buf_full, buf_avail and buf_cnt are decoded from the count register only: glitch-free and with no combinational path from the inputs.
- Pointers use PTR_W bits. Count uses PTR_W+1 bits to distinguish full from empty.

Optional Feature:
- Macro PIPE_BUF_ERR_EN.
- When defined:
  - buf_err[0] sets on a dropped write (buf_we, full, not rd_fire, not flush).
  - buf_err[1] sets on buf_re while empty and not flush.
  - Each bit also issues a $display "BUF:overflow" or "BUF:underflow" with the cycle's buf_cnt.
  - Bits are sticky until rst.
- When undefined: buf_err is tied to 2'b00, with no error logic and no messages. All other behaviour is identical.

Test Plan:
- Reset, then three writes of 0xA1, 0xA2, 0xA3 on consecutive cycles, no reads:
  - buf_ack pulses on the first two only.
  - buf_full is 1 and buf_cnt is 2.
  - 0xA3 is dropped; with PIPE_BUF_ERR_EN, buf_err is 2'b01.
- From full (0xA1, 0xA2), buf_re and buf_we with 0xB0 in the same cycle:
  - buf_dout shows 0xA2 next cycle, buf_cnt stays 2, buf_ack is 1.
  - Two more pops yield 0xA2 then 0xB0.
- Write 0x55 at edge N:
  - buf_avail is 0 during cycle N and 1 from cycle N+1.
  - buf_dout is 0x55; buf_re at N+1 returns buf_cnt to 0 after edge N+1.
- Buffer holding 2 entries, flush together with buf_we of 0x77:
  - After the edge, buf_cnt is 0, buf_avail is 0 and buf_ack is 0.
  - A following write of 0x88 is read back as 0x88.
- buf_re on an empty buffer for 3 cycles:
  - Pointers are unchanged.
  - A subsequent write/read of 0x12 returns 0x12.
  - With PIPE_BUF_ERR_EN, buf_err is 2'b10.
- Assert rst mid-stream with 1 entry and buf_we high:
  - Outputs go to 0 immediately without a clock edge.
  - No buf_ack after rst is released.
  - Wrap-around check: 10 alternating write/pop pairs return data in order.
